// File: rtl/asu_riscv_mul_pkg.sv
// Shared types and constants for the multiplier arbiter slice.
// Holds the FSM state encoding and the operator code that selects a low-word multiply.
package asu_riscv_mul_pkg;

  localparam int         NUM_MUL_REQ = 2;
  localparam logic [1:0] MUL_OP_LOW  = 2'b00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC1 = 2'd1,
    EXEC2 = 2'd2,
    RESP  = 2'd3
  } mul_arb_state_e;

endpackage

// File: rtl/asu_riscv_rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, and a tie goes to
// the requester named by rr.
module asu_riscv_rr_arb2 (
  input  logic [1:0] valid,
  input  logic       rr,
  output logic [1:0] grant
);

  always_comb begin
    if (&valid) grant = rr ? 2'b10 : 2'b01;
    else        grant = valid;
  end

endmodule

// File: rtl/asu_riscv_mul_arbiter.sv
// Round-robin arbiter and sequencer in front of the shared multiplier.
// It accepts one request, drives the multiplier for one or two cycles, then holds the result until it is accepted.
module asu_riscv_mul_arbiter
  import asu_riscv_mul_pkg::*;
#(
  parameter logic RR_INIT = 1'b0,
  parameter int   CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_MUL_REQ-1:0]     req_valid_i,
  output logic [NUM_MUL_REQ-1:0]     req_ready_o,
  input  logic [2*NUM_MUL_REQ-1:0]   req_operator_i,
  input  logic [2*NUM_MUL_REQ-1:0]   req_signed_mode_i,
  input  logic [32*NUM_MUL_REQ-1:0]  req_op_a_i,
  input  logic [32*NUM_MUL_REQ-1:0]  req_op_b_i,
  output logic [NUM_MUL_REQ-1:0]     rsp_valid_o,
  input  logic [NUM_MUL_REQ-1:0]     rsp_ready_i,
  output logic [31:0]                rsp_data_o,
  output logic [1:0]                 mul_operator_o,
  output logic [1:0]                 mul_signed_mode_o,
  output logic [31:0]                mul_op_a_o,
  output logic [31:0]                mul_op_b_o,
  input  logic [31:0]                mul_result_i,
  output logic                       busy_o,
  output logic [CNT_W-1:0]           conflict_cnt_o
);

  mul_arb_state_e state_q, state_d;
  logic           rr_q;
  logic           owner_q;
  logic [1:0]     grant;
  logic           sel;
  logic           load;
  logic           capture;
  logic           park;

  asu_riscv_rr_arb2 u_rr_arb2 (
    .valid (req_valid_i),
    .rr    (rr_q),
    .grant (grant)
  );

  assign sel    = grant[1];
  assign busy_o = (state_q != IDLE);

  // NOTE: every output of this block gets a default first, so no path can leave
  // a signal unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    req_ready_o = '0;
    rsp_valid_o = '0;
    load        = 1'b0;
    capture     = 1'b0;
    park        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rst) req_ready_o = grant;
        if (|grant) begin
          load    = 1'b1;
          state_d = EXEC1;
        end
      end
      EXEC1: begin
        if (mul_operator_o == MUL_OP_LOW) begin
          capture = 1'b1;
          park    = 1'b1;
          state_d = RESP;
        end else begin
          state_d = EXEC2;
        end
      end
      EXEC2: begin
        capture = 1'b1;
        park    = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        rsp_valid_o[owner_q] = 1'b1;
        if (rsp_ready_i[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so that every flop
  // samples values from before the clock edge, whatever the order of evaluation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Parking the operands at zero keeps the multiplier in its idle state between operations.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q              <= RR_INIT;
      owner_q           <= 1'b0;
      mul_operator_o    <= '0;
      mul_signed_mode_o <= '0;
      mul_op_a_o        <= '0;
      mul_op_b_o        <= '0;
      rsp_data_o        <= '0;
      conflict_cnt_o    <= '0;
    end else begin
      if (load) begin
        owner_q           <= sel;
        rr_q              <= ~sel;
        mul_operator_o    <= req_operator_i[{sel, 1'b0} +: 2];
        mul_signed_mode_o <= req_signed_mode_i[{sel, 1'b0} +: 2];
        mul_op_a_o        <= req_op_a_i[{sel, 5'b0} +: 32];
        mul_op_b_o        <= req_op_b_i[{sel, 5'b0} +: 32];
      end else if (park) begin
        mul_operator_o    <= MUL_OP_LOW;
        mul_signed_mode_o <= '0;
        mul_op_a_o        <= '0;
        mul_op_b_o        <= '0;
      end
      if (capture) rsp_data_o <= mul_result_i;
      if ((&req_valid_i) && !(&conflict_cnt_o)) conflict_cnt_o <= conflict_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_asu_riscv_mul_arbiter.sv
// Self-checking bench for asu_riscv_mul_arbiter. A behavioural two-state multiplier feeds mul_result_i,
// and a scoreboard checks response data, owner and latency.
module tb_asu_riscv_mul_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid_i = '0;
  logic [1:0]  req_ready_o;
  logic [3:0]  req_operator_i = '0;
  logic [3:0]  req_signed_mode_i = '0;
  logic [63:0] req_op_a_i = '0;
  logic [63:0] req_op_b_i = '0;
  logic [1:0]  rsp_valid_o;
  logic [1:0]  rsp_ready_i = '0;
  logic [31:0] rsp_data_o;
  logic [1:0]  mul_operator_o;
  logic [1:0]  mul_signed_mode_o;
  logic [31:0] mul_op_a_o;
  logic [31:0] mul_op_b_o;
  logic [31:0] mul_result_i;
  logic        busy_o;
  logic [15:0] conflict_cnt_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic        owner;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sb[$];

  asu_riscv_mul_arbiter #(.RR_INIT(1'b0), .CNT_W(16)) dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid_i       (req_valid_i),
    .req_ready_o       (req_ready_o),
    .req_operator_i    (req_operator_i),
    .req_signed_mode_i (req_signed_mode_i),
    .req_op_a_i        (req_op_a_i),
    .req_op_b_i        (req_op_b_i),
    .rsp_valid_o       (rsp_valid_o),
    .rsp_ready_i       (rsp_ready_i),
    .rsp_data_o        (rsp_data_o),
    .mul_operator_o    (mul_operator_o),
    .mul_signed_mode_o (mul_signed_mode_o),
    .mul_op_a_o        (mul_op_a_o),
    .mul_op_b_o        (mul_op_b_o),
    .mul_result_i      (mul_result_i),
    .busy_o            (busy_o),
    .conflict_cnt_o    (conflict_cnt_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] prod64(input logic [1:0] sm, input logic [31:0] a, input logic [31:0] b);
    logic signed [65:0] ax, bx, p;
    ax = $signed({{34{sm[0] & a[31]}}, a});
    bx = $signed({{34{sm[1] & b[31]}}, b});
    p  = ax * bx;
    return p[63:0];
  endfunction

  // Multiplier model: a high-word op needs one cycle in state 0, then delivers the high word in state 1.
  logic        m_state;
  logic [63:0] m_prod;
  always @(posedge clk or posedge rst) begin
    if (rst)                          m_state <= 1'b0;
    else if (m_state)                 m_state <= 1'b0;
    else if (mul_operator_o != 2'b00) m_state <= 1'b1;
  end
  always_comb begin
    m_prod       = prod64(mul_signed_mode_o, mul_op_a_o, mul_op_b_o);
    mul_result_i = m_state ? m_prod[63:32] : m_prod[31:0];
  end

  // Scoreboard monitor: push on request handshake, check latency and owner on first valid, pop on response handshake.
  logic prev_rsp = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      prev_rsp <= 1'b0;
    end else begin
      if (|(req_valid_i & req_ready_o)) begin
        exp_t e;
        int g;
        logic [63:0] p;
        g       = req_ready_o[1] ? 1 : 0;
        p       = prod64(req_signed_mode_i[g*2 +: 2], req_op_a_i[g*32 +: 32], req_op_b_i[g*32 +: 32]);
        e.owner = g[0];
        e.data  = (req_operator_i[g*2 +: 2] == 2'b00) ? p[31:0] : p[63:32];
        e.due   = cyc + ((req_operator_i[g*2 +: 2] == 2'b00) ? 2 : 3);
        sb.push_back(e);
      end
      if (|rsp_valid_o && !prev_rsp) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp: rsp_valid=%b with empty scoreboard", rsp_valid_o);
        end else begin
          if (cyc !== sb[0].due) begin
            errors++;
            $display("FAIL rsp_latency: got cycle %0d, want cycle %0d", cyc, sb[0].due);
          end
          checks++;
          if (rsp_valid_o !== (sb[0].owner ? 2'b10 : 2'b01)) begin
            errors++;
            $display("FAIL rsp_owner: got %b, want owner %0d", rsp_valid_o, sb[0].owner);
          end
        end
      end
      if (|(rsp_valid_o & rsp_ready_i) && sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (rsp_data_o !== e.data) begin
          errors++;
          $display("FAIL rsp_data: got %h, want %h", rsp_data_o, e.data);
        end
      end
      prev_rsp <= |rsp_valid_o;
    end
  end

  task automatic do_req(input int port, input logic [1:0] op, input logic [1:0] sm,
                        input logic [31:0] a, input logic [31:0] b, output int waits);
    @(posedge clk); #1;
    req_operator_i[port*2 +: 2]    = op;
    req_signed_mode_i[port*2 +: 2] = sm;
    req_op_a_i[port*32 +: 32]      = a;
    req_op_b_i[port*32 +: 32]      = b;
    req_valid_i[port]              = 1'b1;
    waits = 0;
    forever begin
      @(negedge clk);
      if (req_ready_o[port]) break;
      waits++;
      if (waits > 20) begin
        checks++; errors++;
        $display("FAIL req_timeout: port %0d never accepted", port);
        break;
      end
    end
    @(posedge clk); #1;
    req_valid_i[port] = 1'b0;
  endtask

  task automatic wait_rsp(input int port);
    bit seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid_o[port]) begin seen = 1; break; end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL rsp_timeout: port %0d got no response", port);
    end
  endtask

  task automatic accept(input int port);
    @(posedge clk); #1;
    rsp_ready_i[port] = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    rsp_ready_i = '0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses outstanding, want 0", sb.size());
    end
  endtask

  task automatic test_reset();
    req_valid_i = 2'b11;
    repeat (2) @(negedge clk);
    checks++;
    if ({req_ready_o, rsp_valid_o, busy_o} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ready=%b rsp_valid=%b busy=%b, want all 0", req_ready_o, rsp_valid_o, busy_o);
    end
    checks++;
    if ({rsp_data_o, mul_operator_o, mul_signed_mode_o, mul_op_a_o, mul_op_b_o, conflict_cnt_o} !== '0) begin
      errors++;
      $display("FAIL reset_data: data=%h op=%b sm=%b a=%h b=%h cnt=%0d, want 0",
               rsp_data_o, mul_operator_o, mul_signed_mode_o, mul_op_a_o, mul_op_b_o, conflict_cnt_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid_i = '0;
    @(negedge clk);
    checks++;
    if (req_ready_o !== 2'b00) begin
      errors++;
      $display("FAIL idle_ready: got %b, want 00", req_ready_o);
    end
  endtask

  task automatic test_round_robin();
    int grants[$];
    int n_both = 0;
    logic [15:0] cnt0;
    @(negedge clk);
    cnt0 = conflict_cnt_o;
    @(posedge clk); #1;
    req_operator_i = '0; req_signed_mode_i = '0;
    req_op_a_i = {32'd4, 32'd3};
    req_op_b_i = {32'd5, 32'd5};
    rsp_ready_i = 2'b11;
    req_valid_i = 2'b11;
    for (int i = 0; i < 40 && grants.size() < 4; i++) begin
      @(negedge clk);
      if (&req_valid_i) n_both++;
      if (req_ready_o != 2'b00) grants.push_back(req_ready_o[1] ? 1 : 0);
    end
    @(posedge clk); #1;
    req_valid_i = '0;
    @(negedge clk);
    checks++;
    if (grants.size() != 4) begin
      errors++;
      $display("FAIL rr_grant_count: got %0d grants, want 4", grants.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (grants[i] != (i % 2)) begin
          errors++;
          $display("FAIL rr_order[%0d]: got %0d, want %0d", i, grants[i], i % 2);
        end
      end
    end
    checks++;
    if (conflict_cnt_o !== cnt0 + 16'(n_both)) begin
      errors++;
      $display("FAIL conflict_cnt: got %0d, want %0d", conflict_cnt_o, cnt0 + 16'(n_both));
    end
    drain();
    rsp_ready_i = '0;
  endtask

  task automatic test_single_mul();
    int waits;
    do_req(0, 2'b00, 2'b00, 32'd7, 32'd6, waits);
    checks++;
    if (waits != 0) begin
      errors++;
      $display("FAIL mul_ready_same_cycle: waited %0d cycles, want 0", waits);
    end
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rsp_valid_o !== 2'b01 || rsp_data_o !== 32'd42) begin
        errors++;
        $display("FAIL mul_hold[%0d]: valid=%b data=%0d, want 01 42", i, rsp_valid_o, rsp_data_o);
      end
      @(negedge clk);
    end
    accept(0);
  endtask

  task automatic test_mulh();
    int waits;
    do_req(1, 2'b01, 2'b11, 32'h8000_0000, 32'h8000_0000, waits);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({mul_operator_o, mul_signed_mode_o, mul_op_a_o, mul_op_b_o, busy_o, rsp_valid_o} !==
          {2'b01, 2'b11, 32'h8000_0000, 32'h8000_0000, 1'b1, 2'b00}) begin
        errors++;
        $display("FAIL mulh_exec%0d: op=%b sm=%b a=%h b=%h busy=%b vld=%b, want 01 11 80000000 80000000 1 00",
                 i + 1, mul_operator_o, mul_signed_mode_o, mul_op_a_o, mul_op_b_o, busy_o, rsp_valid_o);
      end
    end
    @(negedge clk);
    checks++;
    if ({mul_operator_o, mul_op_a_o, mul_op_b_o} !== '0 || rsp_valid_o !== 2'b10 || rsp_data_o !== 32'h4000_0000) begin
      errors++;
      $display("FAIL mulh_resp: op=%b a=%h vld=%b data=%h, want 00 0 10 40000000",
               mul_operator_o, mul_op_a_o, rsp_valid_o, rsp_data_o);
    end
    accept(1);
  endtask

  task automatic test_high_ops();
    logic [1:0]  ops [2] = '{2'b11, 2'b10};
    logic [1:0]  sms [2] = '{2'b00, 2'b01};
    logic [31:0] bs  [2] = '{32'hFFFF_FFFF, 32'd2};
    logic [31:0] exp [2] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF};
    int waits;
    for (int i = 0; i < 2; i++) begin
      do_req(0, ops[i], sms[i], 32'hFFFF_FFFF, bs[i], waits);
      wait_rsp(0);
      checks++;
      if (rsp_data_o !== exp[i]) begin
        errors++;
        $display("FAIL high_op[%0d]: got %h, want %h", i, rsp_data_o, exp[i]);
      end
      accept(0);
    end
  endtask

  task automatic test_back_pressure();
    int waits;
    do_req(0, 2'b00, 2'b00, 32'd11, 32'd13, waits);
    wait_rsp(0);
    @(posedge clk); #1;
    req_operator_i[3:2] = 2'b00; req_signed_mode_i[3:2] = 2'b00;
    req_op_a_i[63:32] = 32'd5; req_op_b_i[63:32] = 32'd5;
    req_valid_i[1] = 1'b1;
    rsp_ready_i = 2'b10;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid_o !== 2'b01 || rsp_data_o !== 32'd143 || req_ready_o !== 2'b00) begin
        errors++;
        $display("FAIL bp_hold[%0d]: vld=%b data=%0d rdy=%b, want 01 143 00", i, rsp_valid_o, rsp_data_o, req_ready_o);
      end
    end
    @(posedge clk); #1;
    rsp_ready_i = 2'b01;
    @(negedge clk);
    checks++;
    if (req_ready_o !== 2'b00) begin
      errors++;
      $display("FAIL bp_no_early_accept: rdy=%b, want 00", req_ready_o);
    end
    @(posedge clk); #1;
    rsp_ready_i = 2'b11;
    @(negedge clk);
    checks++;
    if (req_ready_o !== 2'b10) begin
      errors++;
      $display("FAIL bp_next_accept: rdy=%b, want 10", req_ready_o);
    end
    @(posedge clk); #1;
    req_valid_i = '0;
    drain();
    rsp_ready_i = '0;
  endtask

  task automatic test_reset_exec2();
    int waits;
    do_req(0, 2'b11, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, waits);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (!busy_o || mul_operator_o !== 2'b11 || conflict_cnt_o == 16'd0) begin
      errors++;
      $display("FAIL pre_reset: busy=%b op=%b cnt=%0d, want 1 11 nonzero", busy_o, mul_operator_o, conflict_cnt_o);
    end
    rst = 1'b1;
    #1;
    sb.delete();
    checks++;
    if ({busy_o, req_ready_o, rsp_valid_o, rsp_data_o, mul_operator_o, mul_signed_mode_o,
         mul_op_a_o, mul_op_b_o, conflict_cnt_o} !== '0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b vld=%b data=%h op=%b a=%h cnt=%0d, want all 0",
               busy_o, rsp_valid_o, rsp_data_o, mul_operator_o, mul_op_a_o, conflict_cnt_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    do_req(0, 2'b00, 2'b00, 32'd3, 32'd3, waits);
    wait_rsp(0);
    checks++;
    if (rsp_data_o !== 32'd9) begin
      errors++;
      $display("FAIL post_reset_mul: got %0d, want 9", rsp_data_o);
    end
    accept(0);
    drain();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_mul();
    test_mulh();
    test_high_ops();
    test_back_pressure();
    test_reset_exec2();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
